regfile_writeback_queue: RTL and testbench

Write-side front end for the 15+1 register file. It buffers writeback requests (dest, data) from the execution and load paths in a small FIFO and drains one per cycle into the register file write port (write_enable / Destination_select / DATA). Writes to R15 are redirected to a PC-load output, because R15 is supplied to the register file externally. It also publishes a busy mask and newest-value forwarding for both read-port selects, so readers see data that has not yet been committed.

---
 rtl/regfile_writeback_queue_if.sv | 24 ++
 rtl/regfile_writeback_queue.sv | 175 +++++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_queue_if.sv
// Producer-side writeback request channel into the register file write queue.
// The producer drives dest/data/valid; the queue answers with ready.
interface regfile_writeback_queue_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_dest;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_dest,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_dest,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO in front of the 15+1 register file: drains one write per cycle,
// redirects R15 writes to a PC load, and forwards not-yet-committed values.
module regfile_writeback_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           wb_stall,
    regfile_writeback_queue_if.slave       wb_in,
    output logic                           write_enable,
    output logic [3:0]                     Destination_select,
    output logic [WIDTH-1:0]               DATA,
    output logic                           pc_load,
    output logic [WIDTH-1:0]               pc_value,
    input  logic [3:0]                     src0_sel,
    input  logic [3:0]                     src1_sel,
    output logic                           src0_hit,
    output logic [WIDTH-1:0]               src0_data,
    output logic                           src1_hit,
    output logic [WIDTH-1:0]               src1_data,
    output logic [14:0]                    busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [3:0]       dest_mem_q [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             we_q, we_d;
    logic             pc_load_q, pc_load_d;
    logic [3:0]       dest_q, dest_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pc_value_q, pc_value_d;

    logic             in_ready;
    logic             push;
    logic             pop;
    logic [3:0]       head_dest;
    logic [WIDTH-1:0] head_data;

    function automatic logic [14:0] dest_onehot(input logic [3:0] d);
        logic [14:0] oh;
        oh = '0;
        for (int j = 0; j < 15; j++) begin
            if (d == 4'(j)) oh[j] = 1'b1;
        end
        return oh;
    endfunction

    // No full-bypass: a full queue refuses even when a pop happens this cycle.
    assign in_ready       = reset & ~flush & (count_q != CntW'(DEPTH));
    assign wb_in.in_ready = in_ready;
    assign push           = wb_in.in_valid & in_ready;
    assign pop            = (count_q != '0) & ~wb_stall & ~flush;
    assign head_dest      = dest_mem_q[rd_ptr_q];
    assign head_data      = data_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        pc_load_d  = 1'b0;
        dest_d     = dest_q;
        data_d     = data_q;
        pc_value_d = pc_value_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                if (head_dest == 4'd15) begin
                    pc_load_d  = 1'b1;
                    pc_value_d = head_data;
                end else begin
                    we_d   = 1'b1;
                    dest_d = head_dest;
                    data_d = head_data;
                end
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            pc_load_q  <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            pc_value_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            pc_load_q  <= pc_load_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            pc_value_q <= pc_value_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem_q[wr_ptr_q] <= wb_in.in_dest;
            data_mem_q[wr_ptr_q] <= wb_in.in_data;
        end
    end

    // Scan oldest to newest (output stage, then head..tail) so later matches win.
    always_comb begin
        logic [PtrW-1:0] idx;
        busy_mask = '0;
        src0_hit  = 1'b0;
        src0_data = '0;
        src1_hit  = 1'b0;
        src1_data = '0;
        idx       = '0;

        if (we_q) begin
            busy_mask = busy_mask | dest_onehot(dest_q);
            if (src0_sel != 4'd15 && dest_q == src0_sel) begin
                src0_hit  = 1'b1;
                src0_data = data_q;
            end
            if (src1_sel != 4'd15 && dest_q == src1_sel) begin
                src1_hit  = 1'b1;
                src1_data = data_q;
            end
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                busy_mask = busy_mask | dest_onehot(dest_mem_q[idx]);
                if (src0_sel != 4'd15 && dest_mem_q[idx] == src0_sel) begin
                    src0_hit  = 1'b1;
                    src0_data = data_mem_q[idx];
                end
                if (src1_sel != 4'd15 && dest_mem_q[idx] == src1_sel) begin
                    src1_hit  = 1'b1;
                    src1_data = data_mem_q[idx];
                end
            end
        end
    end

    assign write_enable       = we_q;
    assign Destination_select = dest_q;
    assign DATA               = data_q;
    assign pc_load            = pc_load_q;
    assign pc_value           = pc_value_q;
    assign count              = count_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: drain order, backpressure,
// forwarding priority, R15 redirect, flush and reset-mid-drain.
module tb_regfile_writeback_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              wb_stall;
    logic              write_enable;
    logic [3:0]        Destination_select;
    logic [WIDTH-1:0]  DATA;
    logic              pc_load;
    logic [WIDTH-1:0]  pc_value;
    logic [3:0]        src0_sel;
    logic [3:0]        src1_sel;
    logic              src0_hit;
    logic [WIDTH-1:0]  src0_data;
    logic              src1_hit;
    logic [WIDTH-1:0]  src1_data;
    logic [14:0]       busy_mask;
    logic [2:0]        count;

    int passed = 0;
    int total  = 0;

    regfile_writeback_queue_if #(.WIDTH(WIDTH)) wb_if ();

    regfile_writeback_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .wb_stall           (wb_stall),
        .wb_in              (wb_if),
        .write_enable       (write_enable),
        .Destination_select (Destination_select),
        .DATA               (DATA),
        .pc_load            (pc_load),
        .pc_value           (pc_value),
        .src0_sel           (src0_sel),
        .src1_sel           (src1_sel),
        .src0_hit           (src0_hit),
        .src0_data          (src0_data),
        .src1_hit           (src1_hit),
        .src1_data          (src1_data),
        .busy_mask          (busy_mask),
        .count              (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [31:0] x);
        wb_if.in_valid = v;
        wb_if.in_dest  = d;
        wb_if.in_data  = x;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        wb_stall = 1'b0;
        src0_sel = 4'd0;
        src1_sel = 4'd0;
        drive(1'b0, 4'd0, 32'h0);

        // Reset state
        step();
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_data", DATA, 32'd0);
        chk("rst_dsel", 32'(Destination_select), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        chk("rst_ready_low", 32'(wb_if.in_ready), 32'd0);
        chk("rst_hit0", 32'(src0_hit), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready_high", 32'(wb_if.in_ready), 32'd1);

        // Single write, two-cycle latency
        src0_sel = 4'd3;
        drive(1'b1, 4'd3, 32'hDEADBEEF);
        step();
        drive(1'b0, 4'd0, 32'h0);
        chk("sw_count1", 32'(count), 32'd1);
        chk("sw_we_early", 32'(write_enable), 32'd0);
        chk("sw_busy_q", 32'(busy_mask), 32'h0008);
        chk("sw_hit_q", 32'(src0_hit), 32'd1);
        chk("sw_fwd_q", src0_data, 32'hDEADBEEF);
        step();
        chk("sw_we", 32'(write_enable), 32'd1);
        chk("sw_dsel", 32'(Destination_select), 32'd3);
        chk("sw_data", DATA, 32'hDEADBEEF);
        chk("sw_count0", 32'(count), 32'd0);
        chk("sw_busy_out", 32'(busy_mask), 32'h0008);
        chk("sw_hit_out", 32'(src0_hit), 32'd1);
        step();
        chk("sw_we_done", 32'(write_enable), 32'd0);
        chk("sw_busy_done", 32'(busy_mask), 32'h0);
        chk("sw_hit_done", 32'(src0_hit), 32'd0);
        chk("sw_fwd_done", src0_data, 32'h0);

        // Simultaneous push and pop keeps count
        drive(1'b1, 4'd1, 32'h1111);
        step();
        chk("pp_count_a", 32'(count), 32'd1);
        drive(1'b1, 4'd2, 32'h2222);
        step();
        drive(1'b0, 4'd0, 32'h0);
        chk("pp_count_b", 32'(count), 32'd1);
        chk("pp_we_a", 32'(write_enable), 32'd1);
        chk("pp_dsel_a", 32'(Destination_select), 32'd1);
        step();
        chk("pp_dsel_b", 32'(Destination_select), 32'd2);
        chk("pp_data_b", DATA, 32'h2222);
        chk("pp_count_c", 32'(count), 32'd0);
        step();
        chk("pp_we_done", 32'(write_enable), 32'd0);

        // Fill under stall, refuse fifth push, then drain in order
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 32'hA0 + 32'(i));
            step();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(wb_if.in_ready), 32'd0);
        chk("fill_busy", 32'(busy_mask), 32'h001E);
        chk("fill_we", 32'(write_enable), 32'd0);
        drive(1'b1, 4'd6, 32'hA6);
        step();
        chk("fill_refused_count", 32'(count), 32'd4);
        chk("fill_refused_busy", 32'(busy_mask), 32'h001E);
        drive(1'b0, 4'd0, 32'h0);
        wb_stall = 1'b0;
        step();
        chk("drain_we1", 32'(write_enable), 32'd1);
        chk("drain_dsel1", 32'(Destination_select), 32'd1);
        chk("drain_data1", DATA, 32'hA1);
        chk("drain_count3", 32'(count), 32'd3);
        chk("drain_ready", 32'(wb_if.in_ready), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("drain_we", 32'(write_enable), 32'd1);
            chk("drain_dsel", 32'(Destination_select), 32'(k));
            chk("drain_data", DATA, 32'hA0 + 32'(k));
        end
        step();
        chk("drain_we_done", 32'(write_enable), 32'd0);
        chk("drain_count0", 32'(count), 32'd0);
        chk("drain_busy0", 32'(busy_mask), 32'h0);

        // Forwarding priority and R15 exclusion
        wb_stall = 1'b1;
        src0_sel = 4'd5;
        src1_sel = 4'd15;
        drive(1'b1, 4'd5, 32'h11);
        step();
        chk("fwd_first", src0_data, 32'h11);
        drive(1'b1, 4'd5, 32'h22);
        step();
        drive(1'b0, 4'd0, 32'h0);
        chk("fwd_hit0", 32'(src0_hit), 32'd1);
        chk("fwd_newest", src0_data, 32'h22);
        chk("fwd_hit1_r15", 32'(src1_hit), 32'd0);
        chk("fwd_data1_r15", src1_data, 32'h0);
        chk("fwd_busy", 32'(busy_mask), 32'h0020);
        wb_stall = 1'b0;
        step();
        chk("fwd_drain_data", DATA, 32'h11);
        chk("fwd_drain_newest", src0_data, 32'h22);
        step();
        chk("fwd_out_data", DATA, 32'h22);
        chk("fwd_out_count", 32'(count), 32'd0);
        chk("fwd_out_stage", src0_data, 32'h22);
        step();
        chk("fwd_done_hit", 32'(src0_hit), 32'd0);

        // R15 write becomes a PC load
        drive(1'b1, 4'd15, 32'h0000_0100);
        step();
        drive(1'b0, 4'd0, 32'h0);
        chk("pc_count", 32'(count), 32'd1);
        chk("pc_busy_q", 32'(busy_mask), 32'h0);
        chk("pc_hit1_q", 32'(src1_hit), 32'd0);
        step();
        chk("pc_load", 32'(pc_load), 32'd1);
        chk("pc_value", pc_value, 32'h100);
        chk("pc_we", 32'(write_enable), 32'd0);
        chk("pc_dsel_hold", 32'(Destination_select), 32'd5);
        chk("pc_data_hold", DATA, 32'h22);
        chk("pc_busy", 32'(busy_mask), 32'h0);
        step();
        chk("pc_load_pulse", 32'(pc_load), 32'd0);
        chk("pc_value_hold", pc_value, 32'h100);

        // Flush under stall drops queue and same-cycle push
        wb_stall = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            drive(1'b1, 4'(i), 32'h100 * 32'(i));
            step();
        end
        chk("fl_count3", 32'(count), 32'd3);
        chk("fl_busy3", 32'(busy_mask), 32'h0700);
        flush    = 1'b1;
        src0_sel = 4'd7;
        drive(1'b1, 4'd7, 32'h777);
        #1;
        chk("fl_ready", 32'(wb_if.in_ready), 32'd0);
        step();
        chk("fl_count0", 32'(count), 32'd0);
        chk("fl_busy0", 32'(busy_mask), 32'h0);
        chk("fl_we", 32'(write_enable), 32'd0);
        chk("fl_hit7", 32'(src0_hit), 32'd0);
        flush    = 1'b0;
        wb_stall = 1'b0;
        drive(1'b0, 4'd0, 32'h0);
        step();
        chk("fl_we_after1", 32'(write_enable), 32'd0);
        step();
        chk("fl_we_after2", 32'(write_enable), 32'd0);
        chk("fl_count_after", 32'(count), 32'd0);

        // Reset while a write is in flight
        wb_stall = 1'b1;
        drive(1'b1, 4'd2, 32'h200);
        step();
        drive(1'b1, 4'd6, 32'h600);
        step();
        drive(1'b1, 4'd9, 32'h900);
        step();
        drive(1'b0, 4'd0, 32'h0);
        wb_stall = 1'b0;
        step();
        chk("rm_we", 32'(write_enable), 32'd1);
        chk("rm_count2", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        chk("rm_ready_low", 32'(wb_if.in_ready), 32'd0);
        step();
        chk("rm_count0", 32'(count), 32'd0);
        chk("rm_we0", 32'(write_enable), 32'd0);
        chk("rm_pc_load0", 32'(pc_load), 32'd0);
        chk("rm_data0", DATA, 32'h0);
        chk("rm_dsel0", 32'(Destination_select), 32'd0);
        chk("rm_pc_value0", pc_value, 32'h0);
        chk("rm_busy0", 32'(busy_mask), 32'h0);
        chk("rm_ready_still_low", 32'(wb_if.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rm_ready_high", 32'(wb_if.in_ready), 32'd1);
        step();
        chk("rm_we_after", 32'(write_enable), 32'd0);
        chk("rm_count_after", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
